// File: rtl/pwm_pkg.sv
// Shared defaults and state encoding for the PWM capture block.
package pwm_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 32'd100_000;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StHigh,
    StLow
  } cap_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles,
// with a sticky timeout for stuck (0% / 100% duty) inputs.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  // cnt tops out at TIMEOUT+1, so this guarantees it can never wrap.
  if (64'(TIMEOUT) >= (64'd1 << CNT_W) - 64'd1) begin : g_timeout_check
    $error("TIMEOUT must be below 2**CNT_W-1");
  end

  logic s;
  logic s_d_q;
  logic rise;
  logic fall;

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;
  logic             stuck_q, stuck_d;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pwm_in),
    .q  (s)
  );

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    tout_d   = tout_q;
    stuck_d  = stuck_q;

    if (!cap_en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArm;
          cnt_d   = '0;
        end
        StArm: begin
          // First rise only starts timing; there is no prior rise to measure from.
          if (rise) begin
            state_d = StHigh;
            cnt_d   = CNT_W'(1);
          end
        end
        StHigh: begin
          if (fall) begin
            state_d  = StLow;
            shadow_d = cnt_q;
            cnt_d    = cnt_q + CNT_W'(1);
          end else if (cnt_q >= TimeoutCnt) begin
            state_d = StArm;
            tout_d  = 1'b1;
            stuck_d = s;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StLow: begin
          // Edge takes priority over an expiring timeout.
          if (rise) begin
            state_d  = StHigh;
            period_d = cnt_q;
            high_d   = shadow_q;
            valid_d  = 1'b1;
            tout_d   = 1'b0;
            cnt_d    = CNT_W'(1);
          end else if (cnt_q >= TimeoutCnt) begin
            state_d = StArm;
            tout_d  = 1'b1;
            stuck_d = s;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_d_q    <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      s_d_q    <= s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
      stuck_q  <= stuck_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_q;
  assign meas_valid  = valid_q;
  assign timeout     = tout_q;
  assign stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: timestamp-based reference model checked every
// cycle, a table of steady PWM segments, and directed timeout / enable / reset cases.
module tb_pwm_capture;

  localparam int CW = 32;
  localparam int TO = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cap_en;
  logic          pwm_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          timeout;
  logic          stuck_level;

  pwm_capture #(
    .CNT_W  (CW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cap_en     (cap_en),
    .pwm_in     (pwm_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int last_valid = 0;
  int prev_valid = 0;
  int tout_cyc = -1;
  logic tout_prev = 1'b0;

  // Reference model: three-sample delay line of the input, then timestamps of
  // the measured rise and fall; cnt in the design corresponds to (now - t_rise).
  logic s0 = 0, s1 = 0, s2 = 0;
  bit   enabled = 0, running = 0, fall_seen = 0;
  int   t_rise = 0, t_fall = 0;
  int   m_period = 0, m_high = 0;
  bit   m_valid = 0, m_tout = 0, m_stuck = 0;

  typedef struct {
    int per;
    int high;
    int n;
    int exp_per;
    int exp_high;
  } row_t;

  row_t tbl[4];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    logic lvl, rise, fall;
    if (rst) begin
      s0 = 0; s1 = 0; s2 = 0;
      enabled = 0; running = 0; fall_seen = 0;
      m_period = 0; m_high = 0; m_valid = 0; m_tout = 0; m_stuck = 0;
      return;
    end
    lvl  = s1;
    rise = s1 & ~s2;
    fall = ~s1 & s2;
    s2 = s1; s1 = s0; s0 = pwm_in;
    m_valid = 0;
    if (!cap_en) begin
      enabled = 0;
      running = 0;
    end else if (!enabled) begin
      enabled = 1;
    end else if (!running) begin
      if (rise) begin
        running = 1; t_rise = cyc; fall_seen = 0;
      end
    end else if (!fall_seen && fall) begin
      fall_seen = 1; t_fall = cyc;
    end else if (fall_seen && rise) begin
      m_period = cyc - t_rise;
      m_high   = t_fall - t_rise;
      m_valid  = 1;
      m_tout   = 0;
      t_rise   = cyc;
      fall_seen = 0;
    end else if (cyc - t_rise >= TO) begin
      running = 0; m_tout = 1; m_stuck = lvl;
    end
  endtask

  task automatic tick();
    logic [95:0] act, exp;
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    act = {29'd0, meas_valid, timeout, stuck_level, period, high_time};
    exp = {29'd0, m_valid, m_tout, m_stuck, 32'(m_period), 32'(m_high)};
    check("cycle", act, exp);
    if (meas_valid === 1'b1) begin
      n_valid++;
      prev_valid = last_valid;
      last_valid = cyc;
    end
    if (timeout === 1'b1 && !tout_prev) tout_cyc = cyc;
    tout_prev = (timeout === 1'b1);
  endtask

  task automatic run_pwm(input int per, input int high, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < per; i++) begin
        pwm_in = (i < high);
        tick();
      end
    end
  endtask

  initial begin
    int rise_edge;
    int v0;

    tbl[0] = '{per: 1000, high: 400, n: 4, exp_per: 1000, exp_high: 400};
    tbl[1] = '{per: 1000, high: 700, n: 3, exp_per: 1000, exp_high: 700};
    tbl[2] = '{per: 500,  high: 255, n: 3, exp_per: 500,  exp_high: 255};
    tbl[3] = '{per: 500,  high: 100, n: 3, exp_per: 500,  exp_high: 100};

    rst = 1'b1; cap_en = 1'b0; pwm_in = 1'b0;
    tick();
    tick();
    check("reset_outputs", {29'd0, meas_valid, timeout, stuck_level, period, high_time}, '0);
    rst = 1'b0;
    cap_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Steady segments, each change applied mid-run without re-arming.
    for (int r = 0; r < 4; r++) begin
      run_pwm(tbl[r].per, tbl[r].high, tbl[r].n);
      check("row_period", 96'(period), 96'(tbl[r].exp_per));
      check("row_high", 96'(high_time), 96'(tbl[r].exp_high));
      check("row_spacing", 96'(last_valid - prev_valid), 96'(tbl[r].exp_per));
    end

    // Held high: timeout TO cycles after the rise is seen (2-cycle sync latency).
    tout_cyc = -1;
    for (int i = 0; i < TO + 50; i++) begin
      pwm_in = 1'b1;
      tick();
      if (i == 0) rise_edge = cyc;
      if (i == 2) v0 = n_valid;
    end
    check("tout_delay", 96'(tout_cyc - rise_edge), 96'(TO + 2));
    check("tout_high_flag", 96'(timeout), 96'd1);
    check("tout_high_stuck", 96'(stuck_level), 96'd1);
    check("tout_high_no_valid", 96'(n_valid - v0), 96'd0);
    check("tout_hold_period", 96'(period), 96'd500);

    // Held low after a single pulse.
    for (int i = 0; i < 300; i++) begin pwm_in = 1'b0; tick(); end
    for (int i = 0; i < 200; i++) begin pwm_in = 1'b1; tick(); end
    for (int i = 0; i < TO + 50; i++) begin pwm_in = 1'b0; tick(); end
    check("tout_low_flag", 96'(timeout), 96'd1);
    check("tout_low_stuck", 96'(stuck_level), 96'd0);
    run_pwm(500, 100, 2);
    check("tout_cleared", 96'(timeout), 96'd0);
    check("recover_period", 96'(period), 96'd500);
    check("recover_high", 96'(high_time), 96'd100);

    // cap_en dropped mid-high for 10 cycles.
    run_pwm(1000, 400, 2);
    for (int i = 0; i < 3000; i++) begin
      pwm_in = ((i % 1000) < 300);
      cap_en = !(i >= 100 && i < 110);
      tick();
      if (i == 100) v0 = n_valid;
      if (i == 1999) begin
        check("drop_no_valid", 96'(n_valid - v0), 96'd0);
        check("drop_hold_period", 96'(period), 96'd1000);
        check("drop_hold_high", 96'(high_time), 96'd400);
      end
    end
    cap_en = 1'b1;
    check("drop_new_high", 96'(high_time), 96'd300);

    // Reset pulse in the middle of the low phase.
    run_pwm(600, 200, 2);
    for (int i = 0; i < 200; i++) begin
      pwm_in = 1'b0;
      rst = (i == 100);
      tick();
      if (i == 100)
        check("rst_clear", {29'd0, meas_valid, timeout, stuck_level, period, high_time}, '0);
    end
    rst = 1'b0;
    run_pwm(600, 200, 3);
    check("rst_restart_period", 96'(period), 96'd600);
    check("rst_restart_high", 96'(high_time), 96'd200);

    // Random segments with occasional single-cycle enable drops.
    for (int seg = 0; seg < 6; seg++) begin
      int per, high, n;
      per  = $urandom_range(20, 300);
      high = $urandom_range(1, per - 1);
      n    = $urandom_range(2, 5);
      for (int p = 0; p < n; p++) begin
        for (int i = 0; i < per; i++) begin
          pwm_in = (i < high);
          cap_en = ($urandom_range(0, 299) != 0);
          tick();
        end
      end
    end
    cap_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 32, width of all counters and measured values.
REQ-002 Parameter TIMEOUT, default 32'd100_000, cycles without an edge before a measurement is abandoned.
REQ-003 clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cap_en  input  1  capture enable; low aborts and idles the block.
REQ-006 pwm_in  input  1  external PWM; asynchronous to clk.
REQ-007 period  output  CNT_W  clk cycles from one rising edge to the next, from the last completed measurement.
REQ-008 high_time  output  CNT_W  clk cycles pwm_in was high in the last completed measurement.
REQ-009 meas_valid  output  1  one-cycle pulse; period and high_time updated this cycle.
REQ-010 timeout  output  1  sticky flag: no edge seen for TIMEOUT cycles.
REQ-011 stuck_level  output  1  synchronized pwm_in level captured when timeout set.

Function
REQ-012 pwm_in SHALL pass a 2-flop synchronizer, then a 1-flop delay for edge detect; rise = s & ~s_d, fall = ~s & s_d.
REQ-013 Latency: an input edge SHALL be detected 3 clk edges after it is sampled.
REQ-014 States SHALL be IDLE, ARM, HIGH, LOW.
REQ-015 IDLE: cap_en=1 -> ARM; otherwise stay.
REQ-016 ARM: rise -> HIGH, cnt<=1; no meas_valid for the first rise after arming.
REQ-017 HIGH: cnt increments each cycle; fall -> LOW, high_time_shadow<=cnt.
REQ-018 LOW: cnt increments; rise -> HIGH, period<=cnt, high_time<=high_time_shadow, meas_valid=1 same cycle, timeout cleared, cnt<=1.
REQ-019 Counting convention: cnt equals cycles since the rise, so a square wave with H high and P total cycles yields high_time=H and period=P exactly.
REQ-020 In HIGH or LOW, cnt==TIMEOUT without an edge -> ARM, timeout<=1, stuck_level<=s, no meas_valid; this covers 0% and 100% duty.
REQ-021 Rise and timeout in the same cycle: rise wins and timeout is not set.
REQ-022 cap_en low in any state -> IDLE next cycle, no meas_valid; period, high_time, timeout and stuck_level hold their values.
REQ-023 A fall seen in ARM or IDLE SHALL be ignored.
REQ-024 Minimum measurable high or low time is 1 synchronized cycle; shorter pulses may be missed without error.
REQ-025 cnt SHALL never wrap, because TIMEOUT < 2^CNT_W-1 is required; an elaboration check enforces this.

Reset
REQ-026 rst=1 SHALL force the following on the next clk edge: state IDLE, cnt 0, synchronizer flops 0, period 0, high_time 0, meas_valid 0, timeout 0, stuck_level 0.
REQ-027 rst asserted mid-measurement SHALL discard the partial measurement; no meas_valid follows.

Structure
REQ-028 A shared package/header pwm_pkg SHALL hold CNT_W default, state encodings and the default TIMEOUT.
REQ-029 The synchronizer SHALL be a sub-module sync_2ff (parameterized reset value 0); everything else lives in pwm_capture.

Verification
REQ-030 Ideal PWM, period 1000, high 400 cycles, cap_en=1 -> from the 2nd rise on, meas_valid each 1000 cycles with period=1000 and high_time=400.
REQ-031 Change high to 700 mid-run -> the first full period after the change reports 700; no intermediate or garbage value; period stays 1000.
REQ-032 Switch to period 500, high 255, then high 100 -> reports (500,255), then (500,100); meas_valid spacing is 500.
REQ-033 pwm_in held high for more than TIMEOUT cycles (TIMEOUT=2000 in bench) -> timeout=1 and stuck_level=1 exactly 2000 cycles after the last rise, no meas_valid; same with pwm_in held low gives stuck_level=0; the next two rises clear timeout with a valid pulse.
REQ-034 cap_en dropped mid-HIGH, re-raised 10 cycles later -> no meas_valid until two complete rises later; period and high_time hold their old values meanwhile.
REQ-035 rst pulsed for 1 cycle mid-LOW -> all outputs 0 next cycle; measurement restarts from ARM.
